// File: rtl/uart_rx_sampler.sv
// 8N1 UART receive front-end with start-glitch rejection and framing check; UART_RX_PARITY_EN selects 8E1.
// Latency: byte/error strobe registered 1 clk after the stop-bit decision tick.
// Backpressure: none; every strobe is a single cycle and the consumer must take it.
module uart_rx_sampler #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rxd_data,
    output logic       rxd_data_ready,
    output logic       rxd_frame_err,
    output logic       rxd_parity_err,
    output logic       rxd_busy
);

    localparam int SAMPLE_RATE = BAUD * OVERSAMPLE;
    localparam int DIV_RAW     = (CLK_FREQ + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int DIV         = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TICK_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W      = $clog2(OVERSAMPLE);
    localparam int MID         = OVERSAMPLE / 2;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] SAMP_PRE  = SAMP_W'(MID - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(MID);
    localparam logic [SAMP_W-1:0] SAMP_DEC  = SAMP_W'(MID + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic [TICK_W-1:0] tick_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic              vote_a;
    logic              vote_b;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
`ifdef UART_RX_PARITY_EN
    logic              parity_bad;
`endif

    logic tick;
    logic decide;
    logic maj;

    assign tick   = (tick_cnt == TICK_LAST);
    assign decide = tick && (samp_cnt == SAMP_DEC);
    // Third vote is the live sample taken on the decision tick itself.
    assign maj    = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            state          <= S_IDLE;
            tick_cnt       <= '0;
            samp_cnt       <= '0;
            vote_a         <= 1'b1;
            vote_b         <= 1'b1;
            bit_cnt        <= '0;
            shreg          <= '0;
            rxd_data       <= '0;
            rxd_data_ready <= 1'b0;
            rxd_frame_err  <= 1'b0;
            rxd_parity_err <= 1'b0;
            rxd_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad     <= 1'b0;
`endif
        end else begin
            rx_meta        <= rxd;
            rx_s           <= rx_meta;
            rxd_data_ready <= 1'b0;
            rxd_frame_err  <= 1'b0;
            rxd_parity_err <= 1'b0;

            if (state == S_IDLE) begin
                // Hold counters at zero so sampling phase starts at the falling edge.
                tick_cnt <= '0;
                samp_cnt <= '0;
                if (!rx_s) begin
                    state    <= S_START;
                    rxd_busy <= 1'b1;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
                    if (samp_cnt == SAMP_PRE) vote_a <= rx_s;
                    if (samp_cnt == SAMP_MID) vote_b <= rx_s;
                end

                case (state)
                    S_START: begin
                        if (decide) begin
                            if (maj) begin
                                state    <= S_IDLE;
                                rxd_busy <= 1'b0;
                            end else begin
                                state   <= S_DATA;
                                bit_cnt <= '0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (decide) begin
                            shreg   <= {maj, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (decide) begin
                            parity_bad <= (maj != ^shreg);
                            state      <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (decide) begin
                            if (maj) begin
                                // Leave at stop-bit centre so a back-to-back start edge is caught.
                                state    <= S_IDLE;
                                rxd_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                if (parity_bad) begin
                                    rxd_parity_err <= 1'b1;
                                end else begin
                                    rxd_data       <= shreg;
                                    rxd_data_ready <= 1'b1;
                                end
`else
                                rxd_data       <= shreg;
                                rxd_data_ready <= 1'b1;
`endif
                            end else begin
                                rxd_frame_err <= 1'b1;
                                state         <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state    <= S_IDLE;
                            rxd_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        rxd_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
